// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer renderer.
// Holds the palette index type, the 12-bit RGB struct, the transparent index,
// the fixed render latency and the sprite ROM image used by every channel.
package sprite_pkg;

  typedef logic [3:0] pal_idx_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam pal_idx_t TRANSPARENT_IDX = 4'd0;
  localparam int       RENDER_LATENCY  = 2;

  // Sprite ROM image as a pure function of address. Bits [11:8] fold the frame
  // offset in, so consecutive frames differ. The per-channel offset gives each
  // sprite its own artwork. Address 0 of channel 0 holds index 5.
  function automatic pal_idx_t rom_content(input int ch, input logic [31:0] addr);
    return pal_idx_t'(addr[3:0] + addr[11:8] + 4'(5 + 7 * ch));
  endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite layer: frame-synchronous shadow attributes, animation counters,
// hit test, ROM address generation, synchronous ROM and the delayed hit flag.
// Ports: clk_i/rst_ni, frame_start_i, draw_x_i/draw_y_i, live attributes
//        sx_i/sy_i/en_i/flip_i/anim_en_i; hit_o/idx_o are one cycle after the pixel.
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int CH        = 0,
  parameter int SPR_W     = 40,
  parameter int SPR_H     = 40,
  parameter int N_FRAMES  = 4,
  parameter int FRAME_DIV = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic [9:0] sx_i,
  input  logic [9:0] sy_i,
  input  logic       en_i,
  input  logic       flip_i,
  input  logic       anim_en_i,
  output logic       hit_o,
  output logic [3:0] idx_o
);

  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int AW = $clog2(N_FRAMES * SPR_W * SPR_H);

  logic [9:0]    sx_q, sy_q;
  logic          en_q, flip_q, anim_q;
  logic [FW-1:0] frame_q;
  logic [DW-1:0] div_q;
  logic          hit_q;

  // Attributes and animation only move on frame_start. The animation step uses
  // anim_q before this same pulse reloads it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sx_q    <= '0;
      sy_q    <= '0;
      en_q    <= 1'b0;
      flip_q  <= 1'b0;
      anim_q  <= 1'b0;
      frame_q <= '0;
      div_q   <= '0;
    end else if (frame_start_i) begin
      sx_q   <= sx_i;
      sy_q   <= sy_i;
      en_q   <= en_i;
      flip_q <= flip_i;
      anim_q <= anim_en_i;
      if (anim_q) begin
        if (div_q == DW'(FRAME_DIV - 1)) begin
          div_q   <= '0;
          frame_q <= (frame_q == FW'(N_FRAMES - 1)) ? '0 : frame_q + FW'(1);
        end else begin
          div_q <= div_q + DW'(1);
        end
      end
    end
  end

  // 11-bit compare so sprites hanging off the right/bottom edge never wrap.
  logic [10:0] x_ext, y_ext, sx_ext, sy_ext, dx, dy, col;
  logic        hit;
  logic [AW-1:0] addr;

  assign x_ext  = {1'b0, draw_x_i};
  assign y_ext  = {1'b0, draw_y_i};
  assign sx_ext = {1'b0, sx_q};
  assign sy_ext = {1'b0, sy_q};

  assign hit = en_q
            && (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPR_W))
            && (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPR_H));

  assign dx   = x_ext - sx_ext;
  assign dy   = y_ext - sy_ext;
  assign col  = flip_q ? (11'(SPR_W - 1) - dx) : dx;
  assign addr = AW'(frame_q) * AW'(SPR_W * SPR_H) + AW'(dy) * AW'(SPR_W) + AW'(col);

  sprite_rom #(
    .CH (CH),
    .AW (AW)
  ) u_rom (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .addr_i (addr),
    .idx_o  (idx_o)
  );

  // Hit travels alongside the ROM read so both arrive in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hit_q <= 1'b0;
    else         hit_q <= hit;
  end

  assign hit_o = hit_q;

endmodule

// Synchronous sprite ROM: one-cycle registered read of the channel's image.
// Ports: clk_i/rst_ni, addr_i (pixel address), idx_o (palette index, next cycle).
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int CH = 0,
  parameter int AW = 13
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] addr_i,
  output logic [3:0]    idx_o
);

  logic [3:0] idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idx_q <= '0;
    else         idx_q <= rom_content(CH, 32'(addr_i));
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/sprite_layer_renderer.sv
// Multi-sprite renderer between the VGA timing generator and the RGB pins.
// Ports: vga_clk/reset_n, DrawX/DrawY/blank pixel stream, frame_start pulse,
//        packed per-channel sprite attributes; red/green/blue 2 cycles after the pixel.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int          N_SPRITES = 4,
  parameter int          SPR_W     = 40,
  parameter int          SPR_H     = 40,
  parameter int          N_FRAMES  = 4,
  parameter int          FRAME_DIV = 8,
  parameter logic [11:0] BG_RGB    = 12'h000
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    blank,
  input  logic                    frame_start,
  input  logic [N_SPRITES*10-1:0] sprite_x,
  input  logic [N_SPRITES*10-1:0] sprite_y,
  input  logic [N_SPRITES-1:0]    sprite_en,
  input  logic [N_SPRITES-1:0]    sprite_flip,
  input  logic [N_SPRITES-1:0]    sprite_anim_en,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue
);

  logic [N_SPRITES-1:0] hit;
  logic [3:0]           idx [N_SPRITES];

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_ch
    sprite_channel #(
      .CH        (g),
      .SPR_W     (SPR_W),
      .SPR_H     (SPR_H),
      .N_FRAMES  (N_FRAMES),
      .FRAME_DIV (FRAME_DIV)
    ) u_ch (
      .clk_i         (vga_clk),
      .rst_ni        (reset_n),
      .frame_start_i (frame_start),
      .draw_x_i      (DrawX),
      .draw_y_i      (DrawY),
      .sx_i          (sprite_x[10*g +: 10]),
      .sy_i          (sprite_y[10*g +: 10]),
      .en_i          (sprite_en[g]),
      .flip_i        (sprite_flip[g]),
      .anim_en_i     (sprite_anim_en[g]),
      .hit_o         (hit[g]),
      .idx_o         (idx[g])
    );
  end

  logic     blank_q;
  logic     win_vld;
  pal_idx_t win_idx;
  rgb12_t   pal_rgb, rgb_d, rgb_q;

  // Walk from lowest to highest priority so the lowest opaque channel wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = TRANSPARENT_IDX;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit[i] && (idx[i] != TRANSPARENT_IDX)) begin
        win_vld = 1'b1;
        win_idx = idx[i];
      end
    end
  end

  // Fixed 16-entry palette: red ramps up, green ramps down, blue is scrambled.
  always_comb begin
    pal_rgb = {win_idx, ~win_idx, win_idx ^ 4'h5};
    if (!blank_q)     rgb_d = '0;
    else if (win_vld) rgb_d = pal_rgb;
    else              rgb_d = rgb12_t'(BG_RGB);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      blank_q <= blank;
      rgb_q   <= rgb_d;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Bench for sprite_layer_renderer: directed scenarios plus randomized pixels
// against a behavioural frame/pixel model.
module tb_sprite_layer_renderer;

  localparam logic [11:0] BG = 12'h123;

  logic        vga_clk, reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start;
  logic [39:0] sprite_x, sprite_y;
  logic [3:0]  sprite_en, sprite_flip, sprite_anim_en;
  logic [3:0]  red, green, blue;

  sprite_layer_renderer #(
    .N_SPRITES (4), .SPR_W (40), .SPR_H (40),
    .N_FRAMES (4), .FRAME_DIV (8), .BG_RGB (BG)
  ) dut (
    .vga_clk (vga_clk), .reset_n (reset_n),
    .DrawX (DrawX), .DrawY (DrawY), .blank (blank), .frame_start (frame_start),
    .sprite_x (sprite_x), .sprite_y (sprite_y),
    .sprite_en (sprite_en), .sprite_flip (sprite_flip), .sprite_anim_en (sprite_anim_en),
    .red (red), .green (green), .blue (blue)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int sh_x [4];
  int sh_y [4];
  bit sh_en [4];
  bit sh_flip [4];
  bit sh_anim [4];
  int pulses [4];          // animation pulses counted while running
  logic [11:0] pipe_q [$]; // expected colours in flight

  function automatic logic [11:0] pal(input int i);
    logic [3:0] r, g, b;
    r = 4'(i);
    g = 4'(15 - i);
    b = 4'(i ^ 5);
    return {r, g, b};
  endfunction

  function automatic logic [11:0] model_px(input int x, input int y, input bit b);
    int col, a, ix, fr;
    if (!b) return 12'h000;
    for (int ch = 0; ch < 4; ch++) begin
      if (sh_en[ch] && x >= sh_x[ch] && x < sh_x[ch] + 40 && y >= sh_y[ch] && y < sh_y[ch] + 40) begin
        col = sh_flip[ch] ? 39 - (x - sh_x[ch]) : x - sh_x[ch];
        fr  = (pulses[ch] / 8) % 4;
        a   = fr * 1600 + (y - sh_y[ch]) * 40 + col;
        ix  = ((a % 16) + ((a / 256) % 16) + 5 + 7 * ch) % 16;
        if (ix != 0) return pal(ix);
      end
    end
    return BG;
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      sh_x[ch] = 0; sh_y[ch] = 0; sh_en[ch] = 0; sh_flip[ch] = 0; sh_anim[ch] = 0; pulses[ch] = 0;
    end
  endfunction

  function automatic void model_frame_start();
    for (int ch = 0; ch < 4; ch++) begin
      if (sh_anim[ch]) pulses[ch]++;
      sh_x[ch]    = int'(sprite_x[ch*10 +: 10]);
      sh_y[ch]    = int'(sprite_y[ch*10 +: 10]);
      sh_en[ch]   = sprite_en[ch];
      sh_flip[ch] = sprite_flip[ch];
      sh_anim[ch] = sprite_anim_en[ch];
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic set_attr(input int ch, input int x, input int y, input bit en, input bit fl, input bit an);
    sprite_x[ch*10 +: 10] = 10'(x);
    sprite_y[ch*10 +: 10] = 10'(y);
    sprite_en[ch]      = en;
    sprite_flip[ch]    = fl;
    sprite_anim_en[ch] = an;
  endtask

  // Called at posedge+1. Returns the output now visible and the expected value
  // of the pixel driven two calls earlier, then presents a new pixel.
  task automatic drive_px(input int x, input int y, input bit b, input bit fs,
                          output bit vld, output logic [11:0] got, output logic [11:0] exp);
    vld = 1'b0;
    got = {red, green, blue};
    exp = 12'h000;
    if (pipe_q.size() == 2) begin
      exp = pipe_q.pop_front();
      vld = 1'b1;
    end
    DrawX = 10'(x); DrawY = 10'(y); blank = b; frame_start = fs;
    pipe_q.push_back(model_px(x, y, b));
    if (fs) model_frame_start();
    @(posedge vga_clk); #1;
  endtask

  task automatic pulse();
    bit v; logic [11:0] g, e;
    drive_px(0, 0, 0, 1, v, g, e);
  endtask

  // Present one pixel between blanked neighbours; returns its output exactly
  // two cycles later and the model's expectation for it.
  task automatic probe(input int x, input int y, output logic [11:0] got, output logic [11:0] exp);
    bit v; logic [11:0] g, e;
    drive_px(x, y, 1, 0, v, g, e);
    drive_px(x, y, 0, 0, v, g, e);
    drive_px(x, y, 0, 0, v, g, e);
    got = g; exp = e;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit v; logic [11:0] g, e;
    for (int c = 0; c < 4; c++) set_attr(c, 0, 0, 1, 0, 1);
    reset_n = 0; DrawX = 5; DrawY = 5; blank = 1; frame_start = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk); #1;
      checks++;
      if ({red, green, blue} !== 12'h000) begin
        errors++; $display("FAIL reset_hold: rgb=%h expected=%h", {red, green, blue}, 12'h000);
      end
    end
    reset_n = 1;
    pipe_q.delete();
    model_reset();
    for (int i = 0; i < 24; i++) begin
      drive_px($urandom_range(0, 39), $urandom_range(0, 39), 1, 0, v, g, e);
      if (v) begin
        checks++;
        if (g !== BG) begin errors++; $display("FAIL reset_bg: rgb=%h expected=%h", g, BG); end
      end
    end
  endtask

  task automatic test_basic();
    int px [6] = '{100, 99, 140, 101, 139, 100};
    int py [6] = '{50, 50, 50, 50, 89, 90};
    logic [11:0] want [6] = '{12'h5A0, BG, BG, 12'h693, 12'hA5F, BG};
    bit v; logic [11:0] g, e;
    for (int c = 0; c < 4; c++) set_attr(c, 0, 0, 0, 0, 0);
    set_attr(0, 100, 50, 1, 0, 0);
    pulse();
    for (int i = 0; i < 6; i++) begin
      probe(px[i], py[i], g, e);
      checks++;
      if (g !== want[i] || g !== e) begin
        errors++; $display("FAIL basic(%0d,%0d): rgb=%h expected=%h model=%h", px[i], py[i], g, want[i], e);
      end
    end
    for (int x = 95; x <= 145; x++) begin
      drive_px(x, 55, 1, 0, v, g, e);
      if (v) begin
        checks++;
        if (g !== e) begin errors++; $display("FAIL back_to_back x=%0d: rgb=%h expected=%h", x, g, e); end
      end
    end
  endtask

  task automatic test_priority();
    int px [3] = '{200, 211, 240};
    logic [11:0] want [3] = '{12'h5A0, 12'h782, BG};
    logic [11:0] g, e;
    set_attr(0, 200, 100, 1, 0, 0);
    set_attr(1, 200, 100, 1, 0, 0);
    pulse();
    for (int i = 0; i < 3; i++) begin
      probe(px[i], 100, g, e);
      checks++;
      if (g !== want[i] || g !== e) begin
        errors++; $display("FAIL priority x=%0d: rgb=%h expected=%h model=%h", px[i], g, want[i], e);
      end
    end
    set_attr(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flip_clip();
    int px [6] = '{100, 139, 620, 639, 0, 19};
    int py [6] = '{50, 50, 0, 0, 0, 0};
    logic [11:0] want [6] = '{12'hC39, 12'h5A0, 12'h5A0, 12'h87D, BG, BG};
    logic [11:0] g, e;
    set_attr(0, 100, 50, 1, 1, 0);
    pulse();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        set_attr(0, 620, 0, 1, 0, 0);
        pulse();
      end
      probe(px[i], py[i], g, e);
      checks++;
      if (g !== want[i] || g !== e) begin
        errors++; $display("FAIL flip_clip(%0d,%0d): rgb=%h expected=%h model=%h", px[i], py[i], g, want[i], e);
      end
    end
  endtask

  task automatic test_midframe();
    int px [4] = '{300, 400, 300, 400};
    logic [11:0] want [4] = '{12'h5A0, BG, BG, 12'h5A0};
    logic [11:0] g, e;
    set_attr(0, 300, 200, 1, 0, 0);
    pulse();
    set_attr(0, 400, 200, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) pulse();
      probe(px[i], 200, g, e);
      checks++;
      if (g !== want[i] || g !== e) begin
        errors++; $display("FAIL midframe step%0d x=%0d: rgb=%h expected=%h model=%h", i, px[i], g, want[i], e);
      end
    end
  endtask

  task automatic test_anim();
    logic [11:0] g, e, want;
    bit has_want;
    set_attr(0, 100, 50, 1, 0, 1);
    pulse();  // loads anim_en; this pulse does not count yet
    for (int n = 1; n <= 48; n++) begin
      if (n == 40) sprite_anim_en[0] = 1'b0;
      pulse();
      probe(100, 50, g, e);
      has_want = 1'b1;
      case (n)
        7:       want = 12'h5A0;
        8:       want = 12'hB4E;
        16:      want = 12'h1E4;
        24:      want = 12'h782;
        32:      want = 12'h5A0;
        default: begin want = 12'hB4E; has_want = (n >= 40); end
      endcase
      checks++;
      if (g !== e || (has_want && g !== want)) begin
        errors++; $display("FAIL anim pulse%0d: rgb=%h expected=%h model=%h", n, g, want, e);
      end
    end
  endtask

  task automatic test_random();
    bit v; logic [11:0] g, e;
    int c, x, y;
    bit fs, b;
    for (int i = 0; i < 900; i++) begin
      if (i % 60 == 0)
        for (int k = 0; k < 4; k++)
          set_attr(k, $urandom_range(0, 639), $urandom_range(0, 479),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      c  = $urandom_range(0, 3);
      x  = int'(sprite_x[c*10 +: 10]) + int'($urandom_range(0, 49)) - 5;
      y  = int'(sprite_y[c*10 +: 10]) + int'($urandom_range(0, 49)) - 5;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      fs = ($urandom_range(0, 19) == 0);
      b  = ($urandom_range(0, 9) != 0);
      drive_px(x, y, b, fs, v, g, e);
      if (v) begin
        checks++;
        if (g !== e) begin errors++; $display("FAIL random i=%0d (%0d,%0d): rgb=%h expected=%h", i, x, y, g, e); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit v; logic [11:0] g, e;
    for (int c = 0; c < 4; c++) set_attr(c, 0, 0, 0, 0, 0);
    set_attr(0, 100, 50, 1, 0, 0);
    pulse();
    for (int i = 0; i < 3; i++) drive_px(100, 50, 1, 0, v, g, e);
    checks++;
    if (!v || g !== e || g === 12'h000) begin
      errors++; $display("FAIL pre_reset: rgb=%h expected=%h", g, e);
    end
    reset_n = 0;
    #1;
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL reset_async: rgb=%h expected=%h", {red, green, blue}, 12'h000);
    end
    @(posedge vga_clk); #1;
    reset_n = 1;
    pipe_q.delete();
    model_reset();
    probe(100, 50, g, e);
    checks++;
    if (g !== BG || g !== e) begin
      errors++; $display("FAIL post_reset_hidden: rgb=%h expected=%h", g, BG);
    end
  endtask

  initial begin
    sprite_x = '0; sprite_y = '0; sprite_en = '0; sprite_flip = '0; sprite_anim_en = '0;
    DrawX = '0; DrawY = '0; blank = 0; frame_start = 0; reset_n = 0;
    model_reset();
    #2;
    test_reset();
    test_basic();
    test_priority();
    test_flip_clip();
    test_midframe();
    test_anim();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/sprite_layer_renderer.md
# sprite_layer_renderer

Multi-sprite pixel renderer in the VGA pixel pipeline, between the VGA controller (DrawX/DrawY/blank) and the RGB output pins. It supports N_SPRITES independently positioned, animated, horizontally flippable sprites. Each sprite has a synchronous sprite ROM and a fixed priority, and palette index 0 is transparent. This block generalises the single-sprite drawer: sprite count, sprite size and frame count are parameters, attributes are tear-free, and the pipeline is fully registered with a known latency.

## Interface
- N_SPRITES, 4: number of sprite channels; channel 0 has highest priority.
- SPR_W, 40: sprite width in pixels.
- SPR_H, 40: sprite height in pixels.
- N_FRAMES, 4: animation frames per sprite ROM, stored consecutively.
- FRAME_DIV, 8: frame_start pulses per animation step.
- BG_RGB, 12'h000: background colour {r,g,b} where no opaque sprite pixel hits.
- vga_clk  in  1  pixel clock; everything is on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- blank  in  1  high = active video.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- sprite_x, sprite_y  in  N_SPRITES×10 each  top-left position; channel i occupies bits [10i+9:10i].
- sprite_en, sprite_flip, sprite_anim_en  in  N_SPRITES each  per-channel enable, horizontal mirror, animation run.
- red, green, blue  out  4 each  registered pixel colour.

## Operation
- Shadow attributes: sprite_x/y/en/flip/anim_en are copied into per-channel shadow registers only on a cycle with frame_start=1. Rendering uses shadow values only, so mid-frame writes never tear.
- Animation per channel: a div counter (clog2(FRAME_DIV) bits) and a frame index (clog2(N_FRAMES) bits).
  - On frame_start with shadow anim_en=1: if div==FRAME_DIV-1, div←0 and frame←(frame+1) mod N_FRAMES; otherwise div←div+1.
  - With anim_en=0, both the div counter and the frame index hold.
  - The anim_en tested is the value before that same pulse's shadow update.
- Hit test: extend the coordinates to 11 bits. hit = en && DrawX≥sx && DrawX<sx+SPR_W && DrawY≥sy && DrawY<sy+SPR_H. Sprites partially beyond x=639 or y=479 clip correctly, with no wrap-around.
- Address: dx=DrawX−sx and dy=DrawY−sy. col = flip ? SPR_W−1−dx : dx. addr = frame·SPR_W·SPR_H + dy·SPR_W + col, width clog2(N_FRAMES·SPR_W·SPR_H). When there is no hit, addr is a don't-care but hit is forced to 0.
- Compose: take the lowest-index channel whose hit=1 and ROM index≠0. Its index goes through the shared 16-entry palette to RGB. If no channel qualifies, output BG_RGB. If blank=0, output 0.

## Timing
- Latency is 2 cycles, fixed:
  - Cycle t: DrawX/DrawY/blank are sampled; hit and address are computed.
  - Cycle t+1: ROM q is valid, and hit/blank are delayed one stage.
  - Cycle t+2: red/green/blue are registered.
- Throughput is one pixel per clock with no stalls.
- Shadow registers take frame_start at edge t. Pixels sampled at t+1 onward use the new attributes.
- Reset (async assert, synchronous deassert by the system):
  - red/green/blue=0, pipeline hit/blank regs=0.
  - Shadows all 0, so all sprites are disabled until the first frame_start.
  - Frame indices and div counters are 0.
- Reset mid-frame: output is 0 immediately. After release, sprites stay invisible until the next frame_start.

## Structure
- Package sprite_pkg holds:
  - the palette index type (4-bit);
  - the rgb12 struct;
  - the transparent index constant TRANSPARENT_IDX=0;
  - the pipeline latency constant RENDER_LATENCY=2.
- Sub-module sprite_channel, instantiated N_SPRITES times via generate. It contains the shadow registers, animation counters, hit test, address generation, the synchronous ROM instance, and the delayed hit register. It outputs {hit_d, idx}.
- The top level holds the blank delay line, the priority mux, the palette and the output register.

## Test plan
- Reset with frame_start never pulsed, blank=1 → RGB=BG_RGB on every pixel; during reset RGB=0.
- Sprite 0 at (100,50), frame 0, ROM index at (0,0)=5 → pixel (100,50) shows palette[5] exactly 2 cycles after DrawX=100, DrawY=50 is presented. Pixels (99,50) and (140,50) show BG_RGB.
- Sprites 0 and 1 overlap at the same position with both opaque → sprite 0 colour. Where sprite 0's index=0 → sprite 1 colour.
- flip=1 with SPR_W=40 → pixel dx=0 reads ROM col 39. sprite_x=620 → only columns 620–639 are drawn, with no wrap to x=0–19.
- anim_en=1, FRAME_DIV=8, N_FRAMES=4 → frame index advances after pulses 8, 16, 24 and 32, wrapping 3→0. With anim_en=0 the index holds.
- sprite_x changed mid-frame → rendering is unchanged until after the next frame_start pulse.
